// File: rtl/utm_seq_core.sv
`default_nettype none
// ============================================================================
// Module      : utm_seq_core
// Description : Sequential, table-programmable Turing-machine controller.
//               NSTATES states (index NSTATES-1 is HALT), 2**SYM_W symbols
//               (symbol 0 = blank). The transition table is written through
//               cfg_* while idle. The external tape is accessed through a
//               registered req/ack handshake.
// Ports       : clk, rst_n (async, active low)
//               start / busy / halted             run control and status
//               cfg_we / cfg_addr / cfg_wdata      table write, {state,sym} ->
//                                                  {next_state, write_sym, dir}
//               tape_req/we/addr/wdata, tape_rdata/ack   tape RAM handshake
//               state_onehot, head                 machine state and head
// Options     : STEP_LIMIT_EN adds step_limit (in,16) and timeout (out,1);
//               the run is forced to HALT once step_limit MOVEs are done.
// Revision    : 1.0  initial release
// ============================================================================
module utm_seq_core #(
    parameter int NSTATES = 8,
    parameter int SYM_W   = 2,
    parameter int TAPE_AW = 8,
    localparam int ST_W   = $clog2(NSTATES)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic                    busy,
    output logic                    halted,
    input  logic                    cfg_we,
    input  logic [ST_W+SYM_W-1:0]   cfg_addr,
    input  logic [ST_W+SYM_W:0]     cfg_wdata,
    output logic                    tape_req,
    output logic                    tape_we,
    output logic [TAPE_AW-1:0]      tape_addr,
    output logic [SYM_W-1:0]        tape_wdata,
    input  logic [SYM_W-1:0]        tape_rdata,
    input  logic                    tape_ack,
    output logic [NSTATES-1:0]      state_onehot,
    output logic [TAPE_AW-1:0]      head
`ifdef STEP_LIMIT_EN
    ,
    input  logic [15:0]             step_limit,
    output logic                    timeout
`endif
);

    localparam int                c_E_W       = ST_W + SYM_W + 1;
    localparam int                c_TBL_DEPTH = 2 ** (ST_W + SYM_W);
    localparam logic [ST_W-1:0]   c_HALT_ST   = ST_W'(NSTATES - 1);

    localparam logic [2:0] c_S_IDLE  = 3'd0;
    localparam logic [2:0] c_S_READ  = 3'd1;
    localparam logic [2:0] c_S_EXEC  = 3'd2;
    localparam logic [2:0] c_S_WRITE = 3'd3;
    localparam logic [2:0] c_S_MOVE  = 3'd4;
    localparam logic [2:0] c_S_HALT  = 3'd5;

    logic [2:0]         r_fsm;
    logic [ST_W-1:0]    r_state;
    logic [TAPE_AW-1:0] r_head;
    logic [SYM_W-1:0]   r_sym;
    logic [c_E_W-1:0]   r_entry;
    logic               r_req;
    logic               r_we;
    logic [SYM_W-1:0]   r_wdata;
    logic [c_E_W-1:0]   r_table [c_TBL_DEPTH];

    logic               w_busy;
    logic               w_start_ok;
    logic [c_E_W-1:0]   w_lookup;
    logic [SYM_W-1:0]   w_lookup_sym;
    logic [ST_W-1:0]    w_e_next;
    logic               w_e_dir;
    logic               w_next_is_halt;
    logic               w_limit_hit;
    logic               w_goto_halt;

    assign w_busy       = (r_fsm != c_S_IDLE) && (r_fsm != c_S_HALT);
    assign w_start_ok   = start && !w_busy;
    assign w_lookup     = r_table[{r_state, r_sym}];
    assign w_lookup_sym = w_lookup[SYM_W:1];

    // The entry is captured in EXEC so MOVE works from a stable copy.
    assign w_e_next       = r_entry[c_E_W-1 -: ST_W];
    assign w_e_dir        = r_entry[0];
    // Out-of-range next states (non power-of-two NSTATES) also halt.
    assign w_next_is_halt = (w_e_next >= c_HALT_ST);
    assign w_goto_halt    = w_next_is_halt || w_limit_hit;

    // Transition table: writes are only honoured while idle or halted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_TBL_DEPTH; i++) begin
                r_table[i] <= '0;
            end
        end else if (cfg_we && !w_busy) begin
            r_table[cfg_addr] <= cfg_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm   <= c_S_IDLE;
            r_state <= '0;
            r_head  <= '0;
            r_sym   <= '0;
            r_entry <= '0;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_wdata <= '0;
        end else begin
            case (r_fsm)
                c_S_IDLE, c_S_HALT: begin
                    if (start) begin
                        r_fsm   <= c_S_READ;
                        r_state <= '0;
                        r_head  <= '0;
                        r_req   <= 1'b1;
                        r_we    <= 1'b0;
                    end
                end
                c_S_READ: begin
                    if (r_req && tape_ack) begin
                        r_sym <= tape_rdata;
                        r_req <= 1'b0;
                        r_fsm <= c_S_EXEC;
                    end
                end
                c_S_EXEC: begin
                    r_entry <= w_lookup;
                    if (w_lookup_sym == r_sym) begin
                        r_fsm <= c_S_MOVE;
                    end else begin
                        r_fsm   <= c_S_WRITE;
                        r_req   <= 1'b1;
                        r_we    <= 1'b1;
                        r_wdata <= w_lookup_sym;
                    end
                end
                c_S_WRITE: begin
                    if (r_req && tape_ack) begin
                        r_req <= 1'b0;
                        r_we  <= 1'b0;
                        r_fsm <= c_S_MOVE;
                    end
                end
                c_S_MOVE: begin
                    r_head  <= w_e_dir ? (r_head + 1'b1) : (r_head - 1'b1);
                    r_state <= w_next_is_halt ? c_HALT_ST : w_e_next;
                    if (w_goto_halt) begin
                        r_fsm <= c_S_HALT;
                    end else begin
                        r_fsm <= c_S_READ;
                        r_req <= 1'b1;
                    end
                end
                default: r_fsm <= c_S_IDLE;
            endcase
        end
    end

`ifdef STEP_LIMIT_EN
    logic [15:0] r_steps;
    logic        r_timeout;
    logic [15:0] w_steps_inc;

    assign w_steps_inc = r_steps + 16'd1;
    assign w_limit_hit = (step_limit != 16'd0) && (w_steps_inc == step_limit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_steps   <= '0;
            r_timeout <= 1'b0;
        end else if (w_start_ok) begin
            r_steps   <= '0;
            r_timeout <= 1'b0;
        end else if (r_fsm == c_S_MOVE) begin
            r_steps <= w_steps_inc;
            // A genuine HALT takes priority over the limit.
            if (w_limit_hit && !w_next_is_halt) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign timeout = r_timeout;
`else
    assign w_limit_hit = 1'b0;
`endif

    generate
        for (genvar i = 0; i < NSTATES; i++) begin : g_onehot
            assign state_onehot[i] = (r_state == ST_W'(i));
        end
    endgenerate

    assign busy       = w_busy;
    assign halted     = (r_fsm == c_S_HALT);
    assign tape_req   = r_req;
    assign tape_we    = r_we;
    assign tape_addr  = r_head;
    assign tape_wdata = r_wdata;
    assign head       = r_head;

endmodule
`default_nettype wire

// File: tb/tb_utm_seq_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_utm_seq_core
// Description : Self-checking bench for utm_seq_core (8 states, 2-bit
//               symbols, 8-bit tape). Contains a tape RAM model with a
//               programmable ack delay and a step-level Turing-machine
//               reference model. STEP_LIMIT_EN adds the step-limit sequence.
// Revision    : 1.0  initial release
// ============================================================================
module tb_utm_seq_core;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       busy, halted;
    logic       cfg_we = 1'b0;
    logic [4:0] cfg_addr = '0;
    logic [5:0] cfg_wdata = '0;
    logic       tape_req, tape_we;
    logic [7:0] tape_addr;
    logic [1:0] tape_wdata;
    logic [1:0] tape_rdata = '0;
    logic       tape_ack = 1'b0;
    logic [7:0] state_onehot;
    logic [7:0] head;
`ifdef STEP_LIMIT_EN
    logic [15:0] step_limit = '0;
    logic        timeout;
`endif

    utm_seq_core #(.NSTATES(8), .SYM_W(2), .TAPE_AW(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .halted(halted),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .tape_req(tape_req), .tape_we(tape_we), .tape_addr(tape_addr),
        .tape_wdata(tape_wdata), .tape_rdata(tape_rdata), .tape_ack(tape_ack),
        .state_onehot(state_onehot), .head(head)
`ifdef STEP_LIMIT_EN
        , .step_limit(step_limit), .timeout(timeout)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- tape RAM model ----------------
    logic [1:0] tape [256];
    logic [7:0] rd_log [$];
    int         n_wr = 0;
    int         rd_wait = 0;
    int         wr_wait = 0;
    bit         wr_block = 0;
    int         wcnt = 0;

    always @(negedge clk) begin
        if (tape_req && !tape_ack) begin
            if (wcnt >= (tape_we ? wr_wait : rd_wait) && !(tape_we && wr_block)) begin
                tape_ack   = 1'b1;
                tape_rdata = tape_we ? 2'd0 : tape[tape_addr];
            end else begin
                wcnt++;
            end
        end else begin
            tape_ack = 1'b0;
            wcnt     = 0;
        end
    end

    always @(posedge clk) begin
        if (rst_n && tape_req && tape_ack) begin
            if (tape_we) begin
                tape[tape_addr] = tape_wdata;
                n_wr++;
            end else begin
                rd_log.push_back(tape_addr);
            end
        end
    end

    // ---------------- reference model ----------------
    logic [5:0] m_tbl [32];
    logic [1:0] m_tape [256];

    // Plain step-by-step TM semantics; cycle cost per step is the handshake
    // cost of one read, optional write, plus the EXEC and MOVE cycles.
    task automatic model_run(input int w, output bit halts, output int cyc,
                             output int writes, output int fhead);
        int st = 0;
        int hd = 0;
        logic [1:0] sym;
        logic [5:0] e;
        halts = 0; cyc = 0; writes = 0; fhead = 0;
        for (int n = 0; n < 200; n++) begin
            sym = m_tape[hd];
            e   = m_tbl[st * 4 + int'(sym)];
            if (e[2:1] != sym) begin
                m_tape[hd] = e[2:1];
                writes++;
                cyc += (1 + w) + 1 + (1 + w) + 1;
            end else begin
                cyc += (1 + w) + 1 + 1;
            end
            hd = e[0] ? (hd + 1) % 256 : (hd + 255) % 256;
            if (int'(e[5:3]) >= 7) begin
                halts = 1;
                fhead = hd;
                return;
            end
            st = int'(e[5:3]);
        end
    endtask

    // ---------------- helpers ----------------
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        cfg_we = 1'b0;
        rd_wait = 0; wr_wait = 0; wr_block = 0;
        for (int i = 0; i < 256; i++) tape[i] = 2'd0;
        rd_log.delete();
        n_wr = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic cfg_write(input logic [4:0] a, input logic [5:0] d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // Cycles are counted from the edge that accepts start to the edge after
    // which halted is seen.
    task automatic run(input bit with_cfg, input logic [4:0] a, input logic [5:0] d,
                       input int max, output int cyc);
        @(negedge clk);
        start = 1'b1;
        if (with_cfg) begin
            cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        cfg_we = 1'b0;
        cyc = 0;
        while (!halted && cyc < max) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("halt_reached", halted, 1);
    endtask

    typedef struct {
        logic [1:0] sym;
        logic [1:0] wsym;
        logic       dir;
        logic [7:0] exp_head;
        int         exp_cyc;
        logic [1:0] exp_tape0;
        int         exp_wr;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int cyc;
        int mism;
        bit halts;
        int m_cyc, m_wr, m_head;
        logic [7:0] cap_addr;
        logic [1:0] cap_wdata;
        int unstable;

        // single-step runs that halt immediately: {sym, wsym, dir, head, cycles, tape0, writes}
        vecs[0] = '{2'd1, 2'd1, 1'b1, 8'd1,   3, 2'd1, 0};
        vecs[1] = '{2'd2, 2'd3, 1'b1, 8'd1,   4, 2'd3, 1};
        vecs[2] = '{2'd0, 2'd2, 1'b0, 8'd255, 4, 2'd2, 1};
        vecs[3] = '{2'd3, 2'd3, 1'b0, 8'd255, 3, 2'd3, 0};
        vecs[4] = '{2'd0, 2'd0, 1'b1, 8'd1,   3, 2'd0, 0};
        vecs[5] = '{2'd3, 2'd0, 1'b0, 8'd255, 4, 2'd0, 1};

        // ---- reset values ----
        do_reset();
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_req", tape_req, 0);
        chk("rst_we", tape_we, 0);
        chk("rst_wdata", tape_wdata, 0);
        chk("rst_onehot", state_onehot, 8'h01);
        chk("rst_head", head, 0);

        // ---- table-driven single steps ----
        for (int v = 0; v < 6; v++) begin
            do_reset();
            tape[0] = vecs[v].sym;
            cfg_write({3'd0, vecs[v].sym}, {3'd7, vecs[v].wsym, vecs[v].dir});
            run(0, '0, '0, 50, cyc);
            chk("vec_head", head, vecs[v].exp_head);
            chk("vec_cycles", cyc, vecs[v].exp_cyc);
            chk("vec_tape0", tape[0], vecs[v].exp_tape0);
            chk("vec_writes", n_wr, vecs[v].exp_wr);
            chk("vec_onehot", state_onehot, 8'h80);
        end

        // ---- MSB-first binary increment: 1='1', 2='0', 0=blank ----
        // "11" at cells 0..1 becomes "100" at cells 255,0,1.
        do_reset();
        tape[0] = 2'd1; tape[1] = 2'd1;
        cfg_write({3'd0, 2'd1}, {3'd0, 2'd1, 1'b1});   // scan right over '1'
        cfg_write({3'd0, 2'd2}, {3'd0, 2'd2, 1'b1});   // scan right over '0'
        cfg_write({3'd0, 2'd0}, {3'd1, 2'd0, 1'b0});   // end found, go left
        cfg_write({3'd1, 2'd1}, {3'd1, 2'd2, 1'b0});   // 1 -> 0, carry
        cfg_write({3'd1, 2'd2}, {3'd7, 2'd1, 1'b1});   // 0 -> 1, done
        cfg_write({3'd1, 2'd0}, {3'd7, 2'd1, 1'b1});   // new MSB, done
        run(0, '0, '0, 200, cyc);
        chk("inc_cycles", cyc, 21);
        chk("inc_tape255", tape[255], 2'd1);
        chk("inc_tape0", tape[0], 2'd2);
        chk("inc_tape1", tape[1], 2'd2);
        chk("inc_tape2", tape[2], 2'd0);
        chk("inc_writes", n_wr, 3);
        chk("inc_busy", busy, 0);
        chk("inc_head", head, 0);

        // ---- head wrap left; entry for state 0 written with start ----
        do_reset();
        cfg_write({3'd1, 2'd0}, {3'd7, 2'd0, 1'b1});
        run(1, {3'd0, 2'd0}, {3'd1, 2'd0, 1'b0}, 50, cyc);
        chk("wrap_nreads", rd_log.size(), 2);
        if (rd_log.size() >= 2) chk("wrap_addr", rd_log[1], 8'd255);
        chk("wrap_cycles", cyc, 6);
        chk("wrap_head", head, 0);

        // ---- cfg_we while busy is ignored ----
        do_reset();
        cfg_write({3'd0, 2'd0}, {3'd7, 2'd0, 1'b1});
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cfg_we = 1'b1; cfg_addr = {3'd0, 2'd0}; cfg_wdata = {3'd7, 2'd3, 1'b0};
        @(negedge clk);
        cfg_we = 1'b0;
        run(0, '0, '0, 50, cyc);
        chk("busycfg_head", head, 1);
        chk("busycfg_writes", n_wr, 0);

        // ---- stalled write, then asynchronous reset mid-wait ----
        do_reset();
        cfg_write({3'd0, 2'd0}, {3'd7, 2'd3, 1'b1});
        wr_block = 1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 20 && !(tape_req && tape_we); i++) begin
            @(posedge clk);
            #1;
        end
        chk("stall_we", tape_we, 1);
        cap_addr = tape_addr;
        cap_wdata = tape_wdata;
        chk("stall_wdata", cap_wdata, 2'd3);
        chk("stall_addr", cap_addr, 8'd0);
        unstable = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (!tape_req || !tape_we || tape_addr != cap_addr || tape_wdata != cap_wdata)
                unstable++;
        end
        chk("stall_stable", unstable, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_req", tape_req, 0);
        chk("arst_we", tape_we, 0);
        chk("arst_wdata", tape_wdata, 0);
        chk("arst_busy", busy, 0);
        chk("arst_onehot", state_onehot, 8'h01);
        @(negedge clk);
        rst_n = 1'b1;
        wr_block = 0;
        repeat (4) @(posedge clk);
        #1;
        chk("arst_nowrite", n_wr, 0);
        chk("arst_idle_req", tape_req, 0);

        // ---- random tables against the reference model ----
        for (int r = 0; r < 12; r++) begin
            int w;
            int tries;
            w = (r < 4) ? 0 : int'($urandom_range(0, 3));
            do_reset();
            rd_wait = w; wr_wait = w;
            tries = 0;
            halts = 0;
            while (!halts && tries < 50) begin
                for (int i = 0; i < 32; i++)
                    m_tbl[i] = {3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                                1'($urandom_range(0, 1))};
                for (int i = 0; i < 256; i++)
                    m_tape[i] = (i < 16 || i >= 240) ? 2'($urandom_range(0, 3)) : 2'd0;
                for (int i = 0; i < 256; i++) tape[i] = m_tape[i];
                model_run(w, halts, m_cyc, m_wr, m_head);
                tries++;
            end
            for (int i = 0; i < 28; i++) cfg_write(5'(i), m_tbl[i]);
            run(0, '0, '0, m_cyc + 50, cyc);
            mism = 0;
            for (int i = 0; i < 256; i++) if (tape[i] !== m_tape[i]) mism++;
            chk("rnd_tape", mism, 0);
            chk("rnd_cycles", cyc, m_cyc);
            chk("rnd_writes", n_wr, m_wr);
            chk("rnd_head", head, m_head);
            chk("rnd_onehot", state_onehot, 8'h80);
        end

`ifdef STEP_LIMIT_EN
        // ---- step limit on a never-halting table ----
        do_reset();
        step_limit = 16'd10;
        for (int s = 0; s < 4; s++) cfg_write({3'd0, 2'(s)}, {3'd0, 2'(s), 1'b1});
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = {3'd0, 2'd0}; cfg_wdata = {3'd7, 2'd0, 1'b1};
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        cyc = 1;
        while (!halted && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("lim_halted", halted, 1);
        chk("lim_timeout", timeout, 1);
        chk("lim_cycles", cyc, 30);
        chk("lim_head", head, 10);
        step_limit = 16'd0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("lim_clear", timeout, 0);
        chk("lim_busy", busy, 1);
        do_reset();
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
